// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding,
// default frame sync byte and the instruction width used by cd and uc.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam int unsigned INSTR_W      = 16;

endpackage

// File: rtl/prog_loader.sv
// Receives a framed byte stream, writes 16-bit words to program memory from
// address 0, checks the XOR checksum and releases the CPU reset on success.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned AW   = 10,
    parameter logic [7:0]  SYNC = SYNC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               restart,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               error
);

    state_t      state_q, state_d;
    logic        xfer;
    logic [7:0]  len_hi_q;
    logic [7:0]  hi_q;
    logic [7:0]  csum_q;
    logic [AW:0] n_q;
    logic [AW:0] cnt_q;
    logic [AW:0] cnt_inc;
    logic [15:0] n_full;
    logic        oversize;

    assign n_full   = {len_hi_q, rx_data};
    assign oversize = 32'(n_full) > (32'd1 << AW);
    assign cnt_inc  = cnt_q + (AW+1)'(1);
    assign xfer     = rx_valid && rx_ready;

    // Gated by reset so no byte is acknowledged while the loader is held.
    always_comb begin
        rx_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN, ST_ERR: rx_ready = 1'b0;
                default:        rx_ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer && rx_data == SYNC) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (xfer) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if (oversize)           state_d = ST_ERR;
                    else if (n_full == '0)  state_d = ST_CHECK;
                    else                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (xfer) state_d = (cnt_inc == n_q) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
                if (xfer) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (restart) state_d = ST_IDLE;
            end
            ST_ERR: begin
                error = 1'b1;
                if (restart) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi_q  <= '0;
            hi_q      <= '0;
            csum_q    <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (xfer) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_data == SYNC) csum_q <= '0;
                    end
                    ST_LEN_HI: begin
                        len_hi_q <= rx_data;
                        csum_q   <= csum_q ^ rx_data;
                    end
                    ST_LEN_LO: begin
                        n_q    <= (AW+1)'(n_full);
                        cnt_q  <= '0;
                        csum_q <= csum_q ^ rx_data;
                    end
                    ST_DATA_HI: begin
                        hi_q   <= rx_data;
                        csum_q <= csum_q ^ rx_data;
                    end
                    ST_DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_q[AW-1:0];
                        mem_wdata <= {hi_q, rx_data};
                        cnt_q     <= cnt_inc;
                        csum_q    <= csum_q ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
